// File: rtl/axis_tracker_ctrl.sv
// ---------------------------------------------------------------------------
// axis_tracker_ctrl
// Two-axis stepper tracker controller. Each axis compares either a pair of
// light sensors (auto) or a target against the current position (manual),
// then issues a step and waits a settle time. It re-evaluates after each
// settle until no motion is needed.
//
// Ports
//   clk, rst                  single rising-edge clock, synchronous active-high reset
//   sma                       1 = manual target tracking, 0 = auto sensor balancing
//   sample                    one-cycle strobe that starts an evaluation from IDLE
//   R_vertical_1/2            theta sensor pair (unsigned, W bits)
//   R_horizontal_1/2          phi sensor pair (unsigned, W bits)
//   theta_manual, phi_manual  manual-mode target positions
//   s_out_<axis>_<dir>        bit0 = direction enable, bit1 = step pulse
//   theta_actual, phi_actual  position counters
//   lim_theta, lim_phi        sticky flag: a step was blocked by a limit
//   busy                      either axis is out of IDLE
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// axis_tracker_axis
// One axis engine: evaluation FSM, step/settle timers, position counter and
// limit flag.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   sample              evaluation strobe (honoured only in IDLE)
//   sens_1, sens_2      sensor pair; auto error = sens_1 - sens_2
//   target, mode        manual target and mode (1 = manual)
//   drv_pos, drv_neg    drive outputs {step pulse, direction enable}
//   pos                 current position
//   lim                 sticky limit flag
//   busy                engine not in IDLE
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for sample; drives off
// EVAL     | one-cycle decision on the captured error
// MOVE_POS | positive direction enabled; pulse on last divider count
// MOVE_NEG | negative direction enabled; pulse on last divider count
// SETTLE   | drives off for SETTLE_CYC cycles; re-captures inputs at end
// ---------------------------------------------------------------------------
module axis_tracker_axis #(
  parameter int W          = 16,
  parameter int DEADBAND   = 4,
  parameter int STEP_DIV   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int POS_MAX    = 180,
  parameter int POS_INIT   = 90
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sample,
  input  logic [W-1:0] sens_1,
  input  logic [W-1:0] sens_2,
  input  logic [W-1:0] target,
  input  logic         mode,
  output logic [1:0]   drv_pos,
  output logic [1:0]   drv_neg,
  output logic [W-1:0] pos,
  output logic         lim,
  output logic         busy
);

  localparam int SCW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int TCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [SCW-1:0]  STEP_LAST   = SCW'(STEP_DIV - 1);
  localparam logic [TCW-1:0]  SETTLE_LAST = TCW'(SETTLE_CYC - 1);
  localparam logic [W-1:0]    PMAX        = W'(POS_MAX);
  localparam logic [W-1:0]    PINIT       = W'(POS_INIT);
  localparam logic [W-1:0]    PZERO       = '0;
  localparam logic signed [W:0] DB_P      = (W+1)'(DEADBAND);
  localparam logic signed [W:0] DB_N      = -DB_P;
  localparam logic signed [W:0] ERR_ZERO  = '0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EVAL     = 3'd1,
    MOVE_POS = 3'd2,
    MOVE_NEG = 3'd3,
    SETTLE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] step_q, step_d;
  logic [TCW-1:0] settle_q, settle_d;
  logic [W-1:0]   pos_q, pos_d;
  logic           lim_q, lim_d;
  logic [W-1:0]   s1_q, s1_d;
  logic [W-1:0]   s2_q, s2_d;
  logic [W-1:0]   tgt_q, tgt_d;
  logic           mode_q, mode_d;

  logic signed [W:0] err;
  logic              want_pos;
  logic              want_neg;

  // Manual error uses the live position so each re-evaluation sees the
  // result of the step that just completed.
  always_comb begin
    if (mode_q) begin
      err      = $signed({1'b0, tgt_q}) - $signed({1'b0, pos_q});
      want_pos = (err > ERR_ZERO);
      want_neg = (err < ERR_ZERO);
    end else begin
      err      = $signed({1'b0, s1_q}) - $signed({1'b0, s2_q});
      want_pos = (err > DB_P);
      want_neg = (err < DB_N);
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    settle_d = settle_q;
    pos_d    = pos_q;
    lim_d    = lim_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    tgt_d    = tgt_q;
    mode_d   = mode_q;
    drv_pos  = 2'b00;
    drv_neg  = 2'b00;

    case (state_q)
      IDLE: begin
        if (sample) begin
          s1_d    = sens_1;
          s2_d    = sens_2;
          tgt_d   = target;
          mode_d  = mode;
          state_d = EVAL;
        end
      end

      EVAL: begin
        step_d = '0;
        if (want_pos) begin
          if (pos_q == PMAX) begin
            lim_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MOVE_POS;
          end
        end else if (want_neg) begin
          if (pos_q == PZERO) begin
            lim_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = MOVE_NEG;
          end
        end else begin
          state_d = IDLE;
        end
      end

      MOVE_POS: begin
        drv_pos[0] = 1'b1;
        if (step_q == STEP_LAST) begin
          drv_pos[1] = 1'b1;
          if (pos_q != PMAX) pos_d = pos_q + W'(1);
          lim_d    = 1'b0;
          step_d   = '0;
          settle_d = '0;
          state_d  = SETTLE;
        end else begin
          step_d = step_q + SCW'(1);
        end
      end

      MOVE_NEG: begin
        drv_neg[0] = 1'b1;
        if (step_q == STEP_LAST) begin
          drv_neg[1] = 1'b1;
          if (pos_q != PZERO) pos_d = pos_q - W'(1);
          lim_d    = 1'b0;
          step_d   = '0;
          settle_d = '0;
          state_d  = SETTLE;
        end else begin
          step_d = step_q + SCW'(1);
        end
      end

      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          s1_d     = sens_1;
          s2_d     = sens_2;
          tgt_d    = target;
          mode_d   = mode;
          settle_d = '0;
          state_d  = EVAL;
        end else begin
          settle_d = settle_q + TCW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Reset wins in its own cycle: a due step pulse never reaches the pins.
    if (rst) begin
      drv_pos = 2'b00;
      drv_neg = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= '0;
      settle_q <= '0;
      pos_q    <= PINIT;
      lim_q    <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      tgt_q    <= '0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      settle_q <= settle_d;
      pos_q    <= pos_d;
      lim_q    <= lim_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      tgt_q    <= tgt_d;
      mode_q   <= mode_d;
    end
  end

  assign pos  = pos_q;
  assign lim  = lim_q;
  assign busy = (state_q != IDLE);

endmodule

module axis_tracker_ctrl #(
  parameter int W          = 16,
  parameter int DEADBAND   = 4,
  parameter int STEP_DIV   = 4,
  parameter int SETTLE_CYC = 8,
  parameter int POS_MAX    = 180,
  parameter int POS_INIT   = 90
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sma,
  input  logic         sample,
  input  logic [W-1:0] R_vertical_1,
  input  logic [W-1:0] R_vertical_2,
  input  logic [W-1:0] R_horizontal_1,
  input  logic [W-1:0] R_horizontal_2,
  input  logic [W-1:0] theta_manual,
  input  logic [W-1:0] phi_manual,
  output logic [1:0]   s_out_theta_pos,
  output logic [1:0]   s_out_theta_neg,
  output logic [1:0]   s_out_phi_pos,
  output logic [1:0]   s_out_phi_neg,
  output logic [W-1:0] theta_actual,
  output logic [W-1:0] phi_actual,
  output logic         lim_theta,
  output logic         lim_phi,
  output logic         busy
);

  logic busy_theta;
  logic busy_phi;

  axis_tracker_axis #(
    .W(W), .DEADBAND(DEADBAND), .STEP_DIV(STEP_DIV),
    .SETTLE_CYC(SETTLE_CYC), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT)
  ) u_theta (
    .clk     (clk),
    .rst     (rst),
    .sample  (sample),
    .sens_1  (R_vertical_1),
    .sens_2  (R_vertical_2),
    .target  (theta_manual),
    .mode    (sma),
    .drv_pos (s_out_theta_pos),
    .drv_neg (s_out_theta_neg),
    .pos     (theta_actual),
    .lim     (lim_theta),
    .busy    (busy_theta)
  );

  axis_tracker_axis #(
    .W(W), .DEADBAND(DEADBAND), .STEP_DIV(STEP_DIV),
    .SETTLE_CYC(SETTLE_CYC), .POS_MAX(POS_MAX), .POS_INIT(POS_INIT)
  ) u_phi (
    .clk     (clk),
    .rst     (rst),
    .sample  (sample),
    .sens_1  (R_horizontal_1),
    .sens_2  (R_horizontal_2),
    .target  (phi_manual),
    .mode    (sma),
    .drv_pos (s_out_phi_pos),
    .drv_neg (s_out_phi_neg),
    .pos     (phi_actual),
    .lim     (lim_phi),
    .busy    (busy_phi)
  );

  assign busy = busy_theta | busy_phi;

endmodule

// File: tb/tb_axis_tracker_ctrl.sv
module tb_axis_tracker_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sma = 1'b0;
  logic         sample = 1'b0;
  logic [W-1:0] R_vertical_1 = '0;
  logic [W-1:0] R_vertical_2 = '0;
  logic [W-1:0] R_horizontal_1 = '0;
  logic [W-1:0] R_horizontal_2 = '0;
  logic [W-1:0] theta_manual = '0;
  logic [W-1:0] phi_manual = '0;
  logic [1:0]   s_out_theta_pos;
  logic [1:0]   s_out_theta_neg;
  logic [1:0]   s_out_phi_pos;
  logic [1:0]   s_out_phi_neg;
  logic [W-1:0] theta_actual;
  logic [W-1:0] phi_actual;
  logic         lim_theta;
  logic         lim_phi;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  axis_tracker_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .sma             (sma),
    .sample          (sample),
    .R_vertical_1    (R_vertical_1),
    .R_vertical_2    (R_vertical_2),
    .R_horizontal_1  (R_horizontal_1),
    .R_horizontal_2  (R_horizontal_2),
    .theta_manual    (theta_manual),
    .phi_manual      (phi_manual),
    .s_out_theta_pos (s_out_theta_pos),
    .s_out_theta_neg (s_out_theta_neg),
    .s_out_phi_pos   (s_out_phi_pos),
    .s_out_phi_neg   (s_out_phi_neg),
    .theta_actual    (theta_actual),
    .phi_actual      (phi_actual),
    .lim_theta       (lim_theta),
    .lim_phi         (lim_phi),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs from the EVAL cycle until both axes are idle, counting theta pulses
  // and cycles where a pos and neg output of one axis are both active.
  task automatic run_idle(input int budget, output int p_pulses, output int n_pulses,
                          output int overlap, output int timed_out);
    p_pulses  = 0;
    n_pulses  = 0;
    overlap   = 0;
    timed_out = 1;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin
        timed_out = 0;
        break;
      end
      if (s_out_theta_pos == 2'b11) p_pulses++;
      if (s_out_theta_neg == 2'b11) n_pulses++;
      if ((s_out_theta_pos != 2'b00) && (s_out_theta_neg != 2'b00)) overlap++;
      if ((s_out_phi_pos != 2'b00) && (s_out_phi_neg != 2'b00)) overlap++;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int pp, np, ov, to;

    // Reset
    do_reset();
    chk("rst_theta_pos", 32'(s_out_theta_pos), 0);
    chk("rst_theta_neg", 32'(s_out_theta_neg), 0);
    chk("rst_phi_pos",   32'(s_out_phi_pos), 0);
    chk("rst_phi_neg",   32'(s_out_phi_neg), 0);
    chk("rst_theta",     32'(theta_actual), 90);
    chk("rst_phi",       32'(phi_actual), 90);
    chk("rst_busy",      32'(busy), 0);
    chk("rst_lim",       32'({lim_theta, lim_phi}), 0);

    // Auto step: cycle 0 = sample
    sma = 1'b0; R_vertical_1 = 30; R_vertical_2 = 5;
    sample = 1'b1;
    tick(); sample = 1'b0;                                       // cycle 1 EVAL
    chk("auto_c1_busy", 32'(busy), 1);
    chk("auto_c1_drv",  32'(s_out_theta_pos), 0);
    tick(); chk("auto_c2", 32'(s_out_theta_pos), 1);
    tick(); chk("auto_c3", 32'(s_out_theta_pos), 1);
    tick(); chk("auto_c4", 32'(s_out_theta_pos), 1);
    tick(); chk("auto_c5_pulse", 32'(s_out_theta_pos), 3);
    chk("auto_c5_theta", 32'(theta_actual), 90);
    tick(); chk("auto_c6_theta", 32'(theta_actual), 91);         // SETTLE 6..13
    chk("auto_c6_drv", 32'(s_out_theta_pos), 0);
    for (int c = 7; c <= 14; c++) tick();                        // cycle 14 EVAL
    chk("auto_c14_drv", 32'(s_out_theta_pos), 0);
    tick(); chk("auto_c15", 32'(s_out_theta_pos), 1);
    tick(); tick(); tick();
    chk("auto_c18_pulse", 32'(s_out_theta_pos), 3);
    tick(); chk("auto_c19_theta", 32'(theta_actual), 92);
    R_vertical_1 = 10; R_vertical_2 = 10;                        // picked up at cycle 26
    for (int c = 20; c <= 27; c++) tick();
    chk("auto_c27_busy", 32'(busy), 1);
    tick(); chk("auto_c28_busy", 32'(busy), 0);
    chk("auto_final_theta", 32'(theta_actual), 92);
    chk("auto_phi_still", 32'(phi_actual), 90);

    // Deadband on phi
    R_horizontal_1 = 30; R_horizontal_2 = 27;
    sample = 1'b1;
    tick(); sample = 1'b0;
    chk("db_c1_busy", 32'(busy), 1);
    chk("db_c1_drv", 32'({s_out_phi_pos, s_out_phi_neg}), 0);
    tick();
    chk("db_c2_busy", 32'(busy), 0);
    chk("db_c2_drv", 32'({s_out_phi_pos, s_out_phi_neg}), 0);
    chk("db_phi", 32'(phi_actual), 90);
    R_horizontal_1 = 0; R_horizontal_2 = 0;

    // Manual from 90 down to 87
    do_reset();
    chk("rst2_theta", 32'(theta_actual), 90);
    sma = 1'b1; theta_manual = 87; phi_manual = 90;
    sample = 1'b1;
    tick(); sample = 1'b0;
    run_idle(200, pp, np, ov, to);
    chk("man_timeout", 32'(to), 0);
    chk("man_neg_pulses", 32'(np), 3);
    chk("man_pos_pulses", 32'(pp), 0);
    chk("man_overlap", 32'(ov), 0);
    chk("man_theta", 32'(theta_actual), 87);
    chk("man_busy", 32'(busy), 0);
    chk("man_phi", 32'(phi_actual), 90);

    // Drive to upper limit then request further positive motion
    theta_manual = 180;
    sample = 1'b1;
    tick(); sample = 1'b0;
    run_idle(2000, pp, np, ov, to);
    chk("up_timeout", 32'(to), 0);
    chk("up_pulses", 32'(pp), 93);
    chk("up_overlap", 32'(ov), 0);
    chk("up_theta", 32'(theta_actual), 180);
    chk("up_lim", 32'(lim_theta), 0);
    sma = 1'b0; R_vertical_1 = 40; R_vertical_2 = 5;
    sample = 1'b1;
    tick(); sample = 1'b0;
    chk("lim_c1_drv", 32'(s_out_theta_pos), 0);
    tick();
    chk("lim_c2_drv", 32'(s_out_theta_pos), 0);
    chk("lim_c2_busy", 32'(busy), 0);
    chk("lim_flag", 32'(lim_theta), 1);
    chk("lim_theta", 32'(theta_actual), 180);
    chk("lim_phi_flag", 32'(lim_phi), 0);

    // A successful step clears the flag
    sma = 1'b1; theta_manual = 179;
    sample = 1'b1;
    tick(); sample = 1'b0;
    tick(); chk("clr_c2_neg", 32'(s_out_theta_neg), 1);
    chk("clr_c2_lim", 32'(lim_theta), 1);
    tick(); tick(); tick();
    chk("clr_c5_pulse", 32'(s_out_theta_neg), 3);
    tick();
    chk("clr_c6_lim", 32'(lim_theta), 0);
    chk("clr_c6_theta", 32'(theta_actual), 179);
    for (int c = 0; c < 12; c++) tick();
    chk("clr_idle", 32'(busy), 0);

    // Reset in the cycle the pulse is due
    sma = 1'b0; R_vertical_1 = 30; R_vertical_2 = 5;
    sample = 1'b1;
    tick(); sample = 1'b0;
    tick(); tick(); tick();
    chk("rm_c4_drv", 32'(s_out_theta_pos), 1);
    tick();
    rst = 1'b1;
    #1;
    chk("rm_c5_no_pulse", 32'(s_out_theta_pos), 0);
    tick(); rst = 1'b0;
    chk("rm_theta", 32'(theta_actual), 90);
    chk("rm_busy", 32'(busy), 0);
    chk("rm_drv", 32'(s_out_theta_pos), 0);
    tick();
    chk("rm_still_idle", 32'(busy), 0);
    chk("rm_theta_held", 32'(theta_actual), 90);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
